// File: rtl/hirose_msg_padder.sv
// rtl/hirose_msg_padder.sv - byte-to-64-bit block packer with Merkle-Damgard padding
module hirose_msg_padder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic [2:0] {
        ABSORB,
        EMIT_DATA,
        PAD,
        EMIT_PAD,
        EMIT_LEN
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [2:0]  idx_q, idx_d;
    logic [60:0] cnt_q, cnt_d;
    logic        pad_pend_q, pad_pend_d;
    logic        busy_q, busy_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;

    logic        in_fire;
    logic        out_fire;
    logic [5:0]  byte_shift;
    logic [63:0] byte_word;
    logic [63:0] mark_word;

    assign in_fire    = in_valid && in_ready_q;
    assign out_fire   = out_valid_q && out_ready;
    assign byte_shift = {idx_q, 3'b000};
    assign byte_word  = {in_byte, 56'd0} >> byte_shift;
    // Marker lands in the byte after the last data byte; only used when idx < 7.
    assign mark_word  = {8'h80, 56'd0} >> (byte_shift + 6'd8);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pad_pend_d = pad_pend_q;
        busy_d     = busy_q;
        case (state_q)
            ABSORB: begin
                if (in_fire) begin
                    buf_d  = buf_q | byte_word;
                    idx_d  = idx_q + 3'd1;
                    cnt_d  = cnt_q + 61'd1;
                    busy_d = 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d    = EMIT_DATA;
                        pad_pend_d = in_last;
                    end else if (in_last) begin
                        buf_d   = buf_q | byte_word | mark_word;
                        state_d = EMIT_PAD;
                    end
                end
            end
            EMIT_DATA: begin
                if (out_fire) begin
                    buf_d      = 64'd0;
                    idx_d      = 3'd0;
                    pad_pend_d = 1'b0;
                    state_d    = pad_pend_q ? PAD : ABSORB;
                end
            end
            PAD: begin
                buf_d   = 64'h8000_0000_0000_0000;
                state_d = EMIT_PAD;
            end
            EMIT_PAD: begin
                if (out_fire) begin
                    buf_d   = {cnt_q, 3'b000};
                    state_d = EMIT_LEN;
                end
            end
            EMIT_LEN: begin
                if (out_fire) begin
                    buf_d   = 64'd0;
                    idx_d   = 3'd0;
                    cnt_d   = 61'd0;
                    busy_d  = 1'b0;
                    state_d = ABSORB;
                end
            end
            default: state_d = ABSORB;
        endcase
        in_ready_d  = (state_d == ABSORB);
        out_valid_d = (state_d == EMIT_DATA) || (state_d == EMIT_PAD) || (state_d == EMIT_LEN);
        out_last_d  = (state_d == EMIT_LEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ABSORB;
            buf_q       <= 64'd0;
            idx_q       <= 3'd0;
            cnt_q       <= 61'd0;
            pad_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pad_pend_q  <= pad_pend_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = buf_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
endmodule
